// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encodings,
// default sizes and a width helper for counters and indices.
package uart_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;
  localparam int DEF_TMO  = 16;
  localparam int GNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAITACC = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request scanning last+1, last+2, ... mod NREQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GNT_W-1:0] last,
  output logic [GNT_W-1:0] winner,
  output logic             valid
);

  localparam int IW = clog2(NREQ);

  // Scan from the farthest candidate back to the nearest so the nearest set
  // request is the one that sticks, avoiding an early loop exit.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      logic [IW-1:0] sel;
      sel = IW'((int'(last) + i) % NREQ);
      if (req[sel]) begin
        winner = GNT_W'(sel);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter load port among NREQ
// byte sources, with a watchdog on the transmitter taking the byte.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | waiting for tdre=1 and any request; grants on that edge
//  LOAD    | one cycle with ready and ack[w] visible to the outside
//  WAITACC | waiting for tdre to fall; err pulse if it stays high TMO cycles
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int TMO  = DEF_TMO
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data_in,
  input  logic               tdre,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      tx_data,
  output logic               ready,
  output logic [GNT_W-1:0]   gnt_id,
  output logic               busy,
  output logic               err
);

  localparam int IW = clog2(NREQ);
  localparam int TW = clog2(TMO);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GNT_W-1:0] last_q, last_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]    tx_data_q, tx_data_d;
  logic             ready_q, ready_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [GNT_W-1:0] pick_w;
  logic             pick_v;
  logic [IW-1:0]    pick_sel;
  logic [DW-1:0]    bytes [NREQ];
  logic             grant;
  logic             timeout;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_w),
    .valid  (pick_v)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign bytes[g] = data_in[g*DW +: DW];
  end

  assign pick_sel = IW'(pick_w);
  assign grant    = (state_q == ST_IDLE) && tdre && pick_v;
  assign timeout  = (state_q == ST_WAITACC) && tdre && (timer_q == TW'(TMO - 1));

  // State, pointer, timer and all output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      last_q    <= GNT_W'(NREQ - 1);
      ack_q     <= '0;
      tx_data_q <= '0;
      ready_q   <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      ready_q   <= ready_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Next state, watchdog timer and round-robin pointer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_LOAD;
          last_d  = pick_w;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAITACC;
        timer_d = '0;
      end
      ST_WAITACC: begin
        if (!tdre || timeout) state_d = ST_IDLE;
        else                  timer_d = timer_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs; tx_data and gnt_id hold until the next grant.
  always_comb begin
    ack_d     = '0;
    tx_data_d = tx_data_q;
    ready_d   = 1'b0;
    gnt_d     = gnt_q;
    err_d     = timeout;
    busy_d    = (state_d != ST_IDLE);
    if (grant) begin
      ack_d[pick_sel] = 1'b1;
      tx_data_d       = bytes[pick_sel];
      ready_d         = 1'b1;
      gnt_d           = pick_w;
    end
  end

  assign ack     = ack_q;
  assign tx_data = tx_data_q;
  assign ready   = ready_q;
  assign gnt_id  = gnt_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round robin,
// blocked transmitter, watchdog timeout and reset mid-transfer.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  logic               clk;
  logic               clr;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data_in;
  logic               tdre;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      tx_data;
  logic               ready;
  logic [2:0]         gnt_id;
  logic               busy;
  logic               err;

  int checks;
  int failures;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .data_in (data_in),
    .tdre    (tdre),
    .ack     (ack),
    .tx_data (tx_data),
    .ready   (ready),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; req = 4'b1111; tdre = 1'b1; data_in = 32'h13121110;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({ack, tx_data, ready, gnt_id, busy, err} !== '0) begin
        failures++;
        $display("FAIL reset_cycle%0d: ack=%b tx_data=%h ready=%b gnt_id=%0d busy=%b err=%b, required all 0",
                 c, ack, tx_data, ready, gnt_id, busy, err);
      end
    end
    clr = 1'b0; req = 4'b0000;
    step();
    checks++;
    if (ack !== 4'b0000 || ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_after: ack=%b ready=%b busy=%b, required 0000 0 0", ack, ready, busy);
    end
  endtask

  task automatic test_single_grant();
    data_in = 32'h0_0A5_0000 << 0;
    data_in = 32'h00A50000;
    req = 4'b0100; tdre = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1 || ack !== 4'b0100 || tx_data !== 8'hA5 || gnt_id !== 3'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_load: ready=%b ack=%b tx_data=%h gnt_id=%0d busy=%b, required 1 0100 a5 2 1",
               ready, ack, tx_data, gnt_id, busy);
    end
    req = 4'b0000;
    step();
    checks++;
    if (ready !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_wait: ready=%b ack=%b busy=%b tx_data=%h, required 0 0000 1 a5",
               ready, ack, busy, tx_data);
    end
    tdre = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || tx_data !== 8'hA5 || gnt_id !== 3'd2) begin
      failures++;
      $display("FAIL single_idle: busy=%b err=%b tx_data=%h gnt_id=%0d, required 0 0 a5 2",
               busy, err, tx_data, gnt_id);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_id [5];
    logic [7:0] exp_byte [5];
    exp_id   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_byte = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    clr = 1'b1; tdre = 1'b0; req = 4'b0000;
    step();
    clr = 1'b0; data_in = 32'h13121110; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tdre = 1'b1;
      step();
      checks++;
      if (ready !== 1'b1 || gnt_id !== exp_id[g] || tx_data !== exp_byte[g] ||
          ack !== (4'b0001 << exp_id[g])) begin
        failures++;
        $display("FAIL rr_grant%0d: ready=%b gnt_id=%0d tx_data=%h ack=%b, required 1 %0d %h %b",
                 g, ready, gnt_id, tx_data, ack, exp_id[g], exp_byte[g], 4'b0001 << exp_id[g]);
      end
      step();
      tdre = 1'b0;
      step();
    end
    req = 4'b0000;
  endtask

  task automatic test_blocked_tx();
    int bad;
    bad = 0;
    req = 4'b0001; tdre = 1'b0; data_in = 32'h000000C3;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL blocked_cycle%0d: ready=%b busy=%b, required 0 0", c, ready, busy);
      end
    end
    tdre = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1 || gnt_id !== 3'd0 || tx_data !== 8'hC3 || ack !== 4'b0001) begin
      failures++;
      $display("FAIL blocked_release: ready=%b gnt_id=%0d tx_data=%h ack=%b, required 1 0 c3 0001",
               ready, gnt_id, tx_data, ack);
    end
    req = 4'b0000;
    step();
    tdre = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    req = 4'b0010; tdre = 1'b1; data_in = 32'h00005A00;
    step();
    checks++;
    if (ready !== 1'b1 || gnt_id !== 3'd1) begin
      failures++;
      $display("FAIL tmo_grant: ready=%b gnt_id=%0d, required 1 1", ready, gnt_id);
    end
    step();
    for (int c = 1; c < TMO; c++) begin
      step();
      checks++;
      if (err !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
        failures++;
        $display("FAIL tmo_wait%0d: err=%b busy=%b ready=%b, required 0 1 0", c, err, busy, ready);
      end
    end
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL tmo_err: err=%b busy=%b ready=%b, required 1 0 0", err, busy, ready);
    end
    step();
    checks++;
    if (err !== 1'b0 || ready !== 1'b1 || gnt_id !== 3'd1 || ack !== 4'b0010 || tx_data !== 8'h5A) begin
      failures++;
      $display("FAIL tmo_regrant: err=%b ready=%b gnt_id=%0d ack=%b tx_data=%h, required 0 1 1 0010 5a",
               err, ready, gnt_id, ack, tx_data);
    end
    req = 4'b0000;
    step();
    tdre = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_done: busy=%b err=%b, required 0 0", busy, err);
    end
  endtask

  task automatic test_reset_mid_transfer();
    req = 4'b0100; tdre = 1'b1; data_in = 32'h44332211;
    step();
    step();
    step();
    step();
    clr = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || ready !== 1'b0 || ack !== 4'b0000 ||
        tx_data !== 8'h00 || gnt_id !== 3'd0) begin
      failures++;
      $display("FAIL midrst_state: busy=%b err=%b ready=%b ack=%b tx_data=%h gnt_id=%0d, required all 0",
               busy, err, ready, ack, tx_data, gnt_id);
    end
    clr = 1'b0; req = 4'b1111;
    step();
    checks++;
    if (ready !== 1'b1 || gnt_id !== 3'd0 || ack !== 4'b0001 || tx_data !== 8'h11 || err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_first: ready=%b gnt_id=%0d ack=%b tx_data=%h err=%b, required 1 0 0001 11 0",
               ready, gnt_id, ack, tx_data, err);
    end
    req = 4'b0000;
    step();
    tdre = 1'b0;
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    clr = 1'b1; req = '0; tdre = 1'b0; data_in = '0;
    #2;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_blocked_tx();
    test_timeout();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
